prco_pipeline_ctrl: RTL and testbench

Multi-cycle control sequencer for the PRCO core. It owns the PC, fetches instruction words, and drives the decoder through its i_ce/q_ce/q_fetch handshake. It then sequences ALU execute, the optional data-RAM access and register writeback using the decoder's q_reg_we/q_req_ram/q_req_ram_we flags. It sits between instruction memory, prco_decoder, the ALU, data RAM and the register set.

---
 rtl/prco_pipeline_ctrl_pkg.sv | 36 +++
 rtl/prco_ctrl_timeout.sv | 32 +++
 rtl/prco_pipeline_ctrl.sv | 142 ++++++++++++++
 tb/tb_prco_pipeline_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prco_pipeline_ctrl_pkg.sv
`default_nettype none
// prco_pipeline_ctrl_pkg -- state encoding, widths and defaults shared by the PRCO control sequencer.
// Revision 1.0
package prco_pipeline_ctrl_pkg;

  localparam int PRCO_CTRL_STATE_W      = 3;
  localparam int PRCO_CTRL_TMO_W        = 8;
  localparam int PRCO_CTRL_INSTR_W      = 16;
  localparam int PRCO_CTRL_RETIRE_W     = 16;
  localparam int PRCO_CTRL_MEM_TIMEOUT  = 15;
  localparam logic [15:0] PRCO_CTRL_RESET_PC = 16'h0000;

  typedef enum logic [PRCO_CTRL_STATE_W-1:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_DWAIT  = 3'd3,
    S_EXEC   = 3'd4,
    S_MEM    = 3'd5,
    S_WB     = 3'd6,
    S_FAULT  = 3'd7
  } prco_state_t;

  typedef struct packed {
    logic reg_we;
    logic req_ram;
    logic req_ram_we;
  } prco_dec_flags_t;

  // States in which the sequencer is waiting on an external responder.
  function automatic logic prco_is_wait_state(input prco_state_t s);
    return (s == S_FETCH) || (s == S_DWAIT) || (s == S_MEM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/prco_ctrl_timeout.sv
`default_nettype none
// prco_ctrl_timeout -- saturating wait counter shared by the fetch, decode and RAM waits.
// Revision 1.0
module prco_ctrl_timeout
  import prco_pipeline_ctrl_pkg::*;
#(
  parameter int LIMIT = PRCO_CTRL_MEM_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [PRCO_CTRL_TMO_W-1:0] LAST = PRCO_CTRL_TMO_W'(LIMIT - 1);

  logic [PRCO_CTRL_TMO_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt <= '0;
    end else if (enable && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Flags the LIMIT-th waiting cycle so the owner can leave on that same edge.
  assign expired = (cnt >= LAST);

endmodule
`default_nettype wire

// File: rtl/prco_pipeline_ctrl.sv
`default_nettype none
// prco_pipeline_ctrl -- multi-cycle fetch/decode/execute/memory/writeback sequencer for the PRCO core.
// Revision 1.0
module prco_pipeline_ctrl
  import prco_pipeline_ctrl_pkg::*;
#(
  parameter int              PC_W        = 16,
  parameter logic [PC_W-1:0] RESET_PC    = PC_W'(PRCO_CTRL_RESET_PC),
  parameter int              MEM_TIMEOUT = PRCO_CTRL_MEM_TIMEOUT
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_en,
  output logic [PC_W-1:0]               q_pc,
  output logic                          q_imem_req,
  input  logic                          i_imem_ack,
  input  logic [PRCO_CTRL_INSTR_W-1:0]  i_imem_data,
  output logic [PRCO_CTRL_INSTR_W-1:0]  q_instr,
  output logic                          q_dec_ce,
  input  logic                          i_dec_ce,
  input  logic                          i_dec_fetch,
  input  logic                          i_dec_reg_we,
  input  logic                          i_dec_req_ram,
  input  logic                          i_dec_req_ram_we,
  output logic                          q_alu_ce,
  output logic                          q_ram_req,
  output logic                          q_ram_we,
  input  logic                          i_ram_ack,
  output logic                          q_wb_we,
  input  logic                          i_br_valid,
  input  logic [PC_W-1:0]               i_br_target,
  output logic [PRCO_CTRL_STATE_W-1:0]  q_state,
  output logic                          q_fault,
  output logic [PRCO_CTRL_RETIRE_W-1:0] q_retired
);

  prco_state_t     state;
  prco_state_t     state_nx;
  prco_dec_flags_t flags;
  logic            tmo_en;
  logic            tmo_clear;
  logic            tmo_expired;
  logic            skip_retire;
  logic            retire;
  logic            is_store;

  prco_ctrl_timeout #(
    .LIMIT (MEM_TIMEOUT)
  ) u_timeout (
    .clk     (i_clk),
    .rst_n   (i_reset),
    .clear   (tmo_clear),
    .enable  (tmo_en),
    .expired (tmo_expired)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (i_en) state_nx = S_FETCH;
      end
      S_FETCH: begin
        if (i_imem_ack)       state_nx = S_DECODE;
        else if (tmo_expired) state_nx = S_FAULT;
      end
      S_DECODE: begin
        state_nx = S_DWAIT;
      end
      S_DWAIT: begin
        // A valid executable instruction wins over a concurrent skip request.
        if (i_dec_ce)         state_nx = S_EXEC;
        else if (i_dec_fetch) state_nx = i_en ? S_FETCH : S_IDLE;
        else if (tmo_expired) state_nx = S_FAULT;
      end
      S_EXEC: begin
        state_nx = flags.req_ram ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (i_ram_ack)        state_nx = S_WB;
        else if (tmo_expired) state_nx = S_FAULT;
      end
      S_WB: begin
        state_nx = i_en ? S_FETCH : S_IDLE;
      end
      S_FAULT: begin
        state_nx = S_FAULT;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  assign tmo_en      = prco_is_wait_state(state);
  assign tmo_clear   = (state_nx != state);
  assign skip_retire = (state == S_DWAIT) && !i_dec_ce && i_dec_fetch;
  assign retire      = (state == S_WB) || skip_retire;
  assign is_store    = flags.req_ram && flags.req_ram_we;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      q_pc      <= RESET_PC;
      q_instr   <= '0;
      q_retired <= '0;
      flags     <= '0;
    end else begin
      if ((state == S_FETCH) && i_imem_ack) begin
        q_instr <= i_imem_data;
      end
      if ((state == S_DWAIT) && i_dec_ce) begin
        flags.reg_we     <= i_dec_reg_we;
        flags.req_ram    <= i_dec_req_ram;
        flags.req_ram_we <= i_dec_req_ram_we;
      end
      if (retire) begin
        q_retired <= q_retired + 1'b1;
        if ((state == S_WB) && i_br_valid) q_pc <= i_br_target;
        else                                q_pc <= q_pc + 1'b1;
      end
    end
  end

  assign q_imem_req = (state == S_FETCH);
  assign q_dec_ce   = (state == S_DECODE);
  assign q_alu_ce   = (state == S_EXEC);
  assign q_ram_req  = (state == S_MEM);
  assign q_ram_we   = (state == S_MEM) && flags.req_ram_we;
  assign q_wb_we    = (state == S_WB) && flags.reg_we && !is_store;
  assign q_fault    = (state == S_FAULT);
  assign q_state    = state;

endmodule
`default_nettype wire

// File: tb/tb_prco_pipeline_ctrl.sv
`default_nettype none
// tb_prco_pipeline_ctrl -- directed and randomized bench for prco_pipeline_ctrl with a behavioural model.
// Revision 1.0
module tb_prco_pipeline_ctrl;

  localparam int          PC_W   = 16;
  localparam logic [15:0] RST_PC = 16'h0000;
  localparam int          TMO    = 15;

  logic        clk = 1'b0;
  logic        i_reset, i_en, i_imem_ack, i_dec_ce, i_dec_fetch;
  logic        i_dec_reg_we, i_dec_req_ram, i_dec_req_ram_we, i_ram_ack, i_br_valid;
  logic [15:0] i_imem_data;
  logic [15:0] i_br_target;
  logic [15:0] q_pc, q_instr, q_retired;
  logic        q_imem_req, q_dec_ce, q_alu_ce, q_ram_req, q_ram_we, q_wb_we, q_fault;
  logic [2:0]  q_state;

  prco_pipeline_ctrl #(
    .PC_W        (PC_W),
    .RESET_PC    (RST_PC),
    .MEM_TIMEOUT (TMO)
  ) dut (
    .i_clk            (clk),
    .i_reset          (i_reset),
    .i_en             (i_en),
    .q_pc             (q_pc),
    .q_imem_req       (q_imem_req),
    .i_imem_ack       (i_imem_ack),
    .i_imem_data      (i_imem_data),
    .q_instr          (q_instr),
    .q_dec_ce         (q_dec_ce),
    .i_dec_ce         (i_dec_ce),
    .i_dec_fetch      (i_dec_fetch),
    .i_dec_reg_we     (i_dec_reg_we),
    .i_dec_req_ram    (i_dec_req_ram),
    .i_dec_req_ram_we (i_dec_req_ram_we),
    .q_alu_ce         (q_alu_ce),
    .q_ram_req        (q_ram_req),
    .q_ram_we         (q_ram_we),
    .i_ram_ack        (i_ram_ack),
    .q_wb_we          (q_wb_we),
    .i_br_valid       (i_br_valid),
    .i_br_target      (i_br_target),
    .q_state          (q_state),
    .q_fault          (q_fault),
    .q_retired        (q_retired)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Program under test: kind 0=NOP, 1=ALU, 2=load, 3=store.
  int          kind [4];
  int          imw  [4];
  int          rmw  [4];
  logic        rwe  [4];
  logic        both [4];
  logic        br   [4];
  logic [15:0] tgt  [4];
  logic [15:0] word [4];

  logic [15:0] pc_m;
  logic [15:0] ret_m;
  int          alu_n, wb_n, ram_n, cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lat(input int i);
    int c;
    c = imw[i] + 1;
    if (kind[i] == 0) return c + 2;
    c = c + 4;
    if (kind[i] >= 2) c = c + rmw[i] + 1;
    return c;
  endfunction

  function automatic logic exp_wb(input int i);
    return (kind[i] == 2) || ((kind[i] == 1) && rwe[i]);
  endfunction

  task automatic gen(input int i, input int k);
    kind[i] = k;
    imw[i]  = $urandom_range(0, 3);
    rmw[i]  = $urandom_range(0, 4);
    rwe[i]  = (k == 2) ? 1'b1 : 1'($urandom_range(0, 1));
    both[i] = 1'($urandom_range(0, 1));
    br[i]   = ($urandom_range(0, 3) == 0);
    tgt[i]  = 16'($urandom);
    word[i] = 16'($urandom);
  endtask

  task automatic set_instr(input int i, input int k, input int iw, input int rw,
                           input logic we, input logic b, input logic [15:0] t);
    kind[i] = k; imw[i] = iw; rmw[i] = rw; rwe[i] = we; both[i] = 1'b0;
    br[i] = b; tgt[i] = t; word[i] = 16'hA000 + 16'(i);
  endtask

  task automatic idle_inputs();
    i_en = 1'b0; i_imem_ack = 1'b0; i_imem_data = '0; i_dec_ce = 1'b0; i_dec_fetch = 1'b0;
    i_dec_reg_we = 1'b0; i_dec_req_ram = 1'b0; i_dec_req_ram_we = 1'b0;
    i_ram_ack = 1'b0; i_br_valid = 1'b0; i_br_target = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_reset = 1'b0;
    @(negedge clk);
    i_reset = 1'b1;
    pc_m  = RST_PC;
    ret_m = '0;
  endtask

  task automatic apply_model(input int n);
    for (int i = 0; i < n; i++) begin
      ret_m = ret_m + 16'd1;
      pc_m  = ((kind[i] != 0) && br[i]) ? tgt[i] : pc_m + 16'd1;
    end
  endtask

  // Acts as instruction memory, decoder and data RAM for n instructions.
  // mode: 0 normal, 1 no fetch ack, 2 no decoder reply, 3 no RAM ack.
  task automatic run_prog(input int n, input int mode, input int abort_ram);
    int   fcnt, rcnt, decs, acks, idx;
    logic started, done, dec_pend;
    fcnt = 0; rcnt = 0; decs = 0; acks = 0;
    started = 1'b0; done = 1'b0; dec_pend = 1'b0;
    alu_n = 0; wb_n = 0; ram_n = 0; cyc = 0;
    @(negedge clk);
    i_en = 1'b1;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (q_state != 3'd0) started = 1'b1;
      if (started && ((q_state == 3'd0) || q_fault)) begin
        done = 1'b1;
        break;
      end
      if (started) cyc++;
      idx = (decs > 0) ? decs - 1 : 0;
      if (q_alu_ce) alu_n++;
      if (q_wb_we) wb_n++;
      if (q_ram_req) begin
        ram_n++;
        check("ram_we_qual", q_ram_we, kind[idx] == 3);
      end
      if ((abort_ram != 0) && q_ram_req && (ram_n == abort_ram)) begin
        i_reset   = 1'b0;
        i_ram_ack = 1'b1;
        @(negedge clk);
        i_reset   = 1'b1;
        i_ram_ack = 1'b0;
        done = 1'b1;
        break;
      end
      i_imem_ack = 1'b0;
      if (q_imem_req) begin
        if ((mode != 1) && (acks < n) && (fcnt == imw[acks])) begin
          i_imem_ack  = 1'b1;
          i_imem_data = word[acks];
          acks++;
          fcnt = 0;
        end else begin
          fcnt++;
        end
      end
      i_dec_ce = 1'b0; i_dec_fetch = 1'b0;
      i_dec_reg_we = 1'b0; i_dec_req_ram = 1'b0; i_dec_req_ram_we = 1'b0;
      if (dec_pend && (mode != 2)) begin
        if (kind[idx] == 0) begin
          i_dec_fetch      = 1'b1;
          i_dec_reg_we     = 1'($urandom_range(0, 1));
          i_dec_req_ram    = 1'($urandom_range(0, 1));
          i_dec_req_ram_we = 1'($urandom_range(0, 1));
        end else begin
          i_dec_ce         = 1'b1;
          i_dec_fetch      = both[idx];
          i_dec_reg_we     = rwe[idx];
          i_dec_req_ram    = (kind[idx] >= 2);
          i_dec_req_ram_we = (kind[idx] == 3);
        end
      end
      dec_pend = q_dec_ce;
      if (q_dec_ce && (decs < n)) begin
        check("instr_latch", q_instr, word[decs]);
        decs++;
        if (decs == n) i_en = 1'b0;
      end
      i_ram_ack = 1'b0;
      if (q_ram_req) begin
        if ((mode != 3) && (rcnt == rmw[idx])) begin
          i_ram_ack = 1'b1;
          rcnt = 0;
        end else begin
          rcnt++;
        end
      end
      i_br_valid  = (decs > 0) ? br[decs - 1] : 1'b0;
      i_br_target = (decs > 0) ? tgt[decs - 1] : 16'h0000;
    end
    check("run_bounded", done, 1'b1);
    idle_inputs();
  endtask

  task automatic run_and_check(input int n, input string tag);
    int ec, ea, ew, er;
    ec = 0; ea = 0; ew = 0; er = 0;
    for (int i = 0; i < n; i++) begin
      ec += lat(i);
      ea += (kind[i] != 0) ? 1 : 0;
      ew += exp_wb(i) ? 1 : 0;
      er += (kind[i] >= 2) ? rmw[i] + 1 : 0;
    end
    run_prog(n, 0, 0);
    apply_model(n);
    check({tag, "_cycles"}, cyc, ec);
    check({tag, "_alu"}, alu_n, ea);
    check({tag, "_wb"}, wb_n, ew);
    check({tag, "_ram"}, ram_n, er);
    check({tag, "_pc"}, q_pc, pc_m);
    check({tag, "_retired"}, q_retired, ret_m);
    check({tag, "_idle"}, q_state, 3'd0);
  endtask

  task automatic check_fault(input string tag);
    check({tag, "_fault"}, q_fault, 1'b1);
    check({tag, "_state"}, q_state, 3'd7);
    check({tag, "_strobes"}, {q_imem_req, q_dec_ce, q_alu_ce, q_ram_req, q_ram_we, q_wb_we}, 6'd0);
  endtask

  initial begin
    idle_inputs();
    i_reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", q_state, 3'd0);
    check("rst_pc", q_pc, RST_PC);
    check("rst_instr", q_instr, 16'h0000);
    check("rst_retired", q_retired, 16'h0000);
    check("rst_fault", q_fault, 1'b0);
    check("rst_strobes", {q_imem_req, q_dec_ce, q_alu_ce, q_ram_req, q_ram_we, q_wb_we}, 6'd0);
    i_reset = 1'b1;
    pc_m = RST_PC;
    ret_m = '0;

    set_instr(0, 1, 0, 0, 1'b1, 1'b0, 16'h0);
    run_and_check(1, "add");
    set_instr(0, 3, 0, 3, 1'b1, 1'b0, 16'h0);
    run_and_check(1, "sw");
    set_instr(0, 0, 0, 0, 1'b1, 1'b1, 16'h1234);
    run_and_check(1, "nop");
    set_instr(0, 1, 1, 0, 1'b1, 1'b1, 16'hFFFF);
    run_and_check(1, "br_ffff");
    set_instr(0, 1, 0, 0, 1'b0, 1'b0, 16'h0);
    run_and_check(1, "wrap");
    set_instr(0, 2, 2, 1, 1'b1, 1'b1, 16'h0040);
    run_and_check(1, "ld_br40");

    for (int r = 0; r < 14; r++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) gen(i, $urandom_range(0, 3));
      run_and_check(n, "rand");
    end

    set_instr(0, 1, 0, 0, 1'b1, 1'b0, 16'h0);
    run_prog(1, 1, 0);
    check("tmo_fetch_cycles", cyc, TMO);
    check_fault("tmo_fetch");
    i_en = 1'b1;
    i_imem_ack = 1'b1;
    i_ram_ack = 1'b1;
    repeat (8) @(negedge clk);
    check_fault("sticky");
    do_reset();
    check("fault_clear", q_fault, 1'b0);
    check("fault_clear_pc", q_pc, RST_PC);

    set_instr(0, 1, 2, 0, 1'b1, 1'b0, 16'h0);
    run_prog(1, 2, 0);
    check("tmo_dec_cycles", cyc, imw[0] + 2 + TMO);
    check_fault("tmo_dec");
    do_reset();

    set_instr(0, 2, 1, 0, 1'b1, 1'b0, 16'h0);
    run_prog(1, 3, 0);
    check("tmo_ram_cycles", cyc, imw[0] + 4 + TMO);
    check_fault("tmo_ram");
    do_reset();

    set_instr(0, 1, 0, 0, 1'b1, 1'b0, 16'h0);
    run_and_check(1, "pre_abort");
    set_instr(0, 3, 0, 10, 1'b0, 1'b0, 16'h0);
    run_prog(1, 0, 2);
    pc_m = RST_PC;
    ret_m = '0;
    check("abort_state", q_state, 3'd0);
    check("abort_ram_req", q_ram_req, 1'b0);
    check("abort_pc", q_pc, RST_PC);
    check("abort_retired", q_retired, 16'h0000);
    repeat (2) @(negedge clk);
    check("abort_stays_idle", q_state, 3'd0);
    set_instr(0, 1, 0, 0, 1'b1, 1'b0, 16'h0);
    run_and_check(1, "post_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
